line_engine: RTL and testbench

// - Responder side of the CPU graphics line interface; CPU stores raise strobes, this block consumes them.
// - Latches endpoints and color from the strobes, then rasterises the segment with integer Bresenham.
// - Emits one pixel per cycle on a valid/ready stream to the framebuffer writer.
// - Reports idle on line_ready, which the CPU polls before each trigger.

---
 rtl/line_engine_pkg.sv | 15 +
 rtl/line_setup.sv | 55 +++++
 rtl/line_engine.sv | 166 ++++++++++++++++
 tb/tb_line_engine.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/line_engine_pkg.sv
// Shared types and defaults for the line rasteriser: FSM encoding and screen geometry.
package line_engine_pkg;

  localparam int COORD_W_DEF  = 10;
  localparam int SCREEN_W_DEF = 800;
  localparam int SCREEN_H_DEF = 600;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_PREP  = 2'd2,
    ST_DRAW  = 2'd3
  } line_state_e;

endpackage

// File: rtl/line_setup.sv
// Combinational Bresenham setup: steep test and axis swap on the raw endpoints,
// then endpoint ordering and dx/dy/err0/ystep on the already axis-swapped endpoints.
module line_setup #(
  parameter int COORD_W = 10
) (
  input  logic [COORD_W-1:0]        x0,
  input  logic [COORD_W-1:0]        y0,
  input  logic [COORD_W-1:0]        x1,
  input  logic [COORD_W-1:0]        y1,
  output logic                      steep,
  output logic [COORD_W-1:0]        s_x0,
  output logic [COORD_W-1:0]        s_y0,
  output logic [COORD_W-1:0]        s_x1,
  output logic [COORD_W-1:0]        s_y1,
  input  logic [COORD_W-1:0]        a_x0,
  input  logic [COORD_W-1:0]        a_y0,
  input  logic [COORD_W-1:0]        a_x1,
  input  logic [COORD_W-1:0]        a_y1,
  output logic [COORD_W-1:0]        p_x0,
  output logic [COORD_W-1:0]        p_y0,
  output logic [COORD_W-1:0]        p_x1,
  output logic [COORD_W-1:0]        dx,
  output logic [COORD_W-1:0]        dy,
  output logic signed [COORD_W+1:0] err0,
  output logic                      ystep_neg
);

  function automatic logic [COORD_W-1:0] abs_diff(input logic [COORD_W-1:0] a,
                                                  input logic [COORD_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  logic             swap;
  logic [COORD_W-1:0] p_y1;

  always_comb begin
    steep = abs_diff(y1, y0) > abs_diff(x1, x0);
    s_x0  = steep ? y0 : x0;
    s_y0  = steep ? x0 : y0;
    s_x1  = steep ? y1 : x1;
    s_y1  = steep ? x1 : y1;

    // Walk always runs towards increasing major coordinate.
    swap      = a_x0 > a_x1;
    p_x0      = swap ? a_x1 : a_x0;
    p_y0      = swap ? a_y1 : a_y0;
    p_x1      = swap ? a_x0 : a_x1;
    p_y1      = swap ? a_y0 : a_y1;
    dx        = p_x1 - p_x0;
    dy        = abs_diff(p_y1, p_y0);
    err0      = signed'({2'b00, dx >> 1});
    ystep_neg = !(p_y0 < p_y1);
  end

endmodule

// File: rtl/line_engine.sv
// Line rasteriser: latches endpoint/color strobes, rasterises with integer Bresenham,
// and streams one pixel per cycle through a registered valid/ready output.
module line_engine
  import line_engine_pkg::*;
#(
  parameter int COORD_W  = COORD_W_DEF,
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        line_color,
  input  logic [COORD_W-1:0] line_point,
  input  logic               line_color_valid,
  input  logic               line_x0_valid,
  input  logic               line_y0_valid,
  input  logic               line_x1_valid,
  input  logic               line_y1_valid,
  input  logic               line_trigger,
  output logic               line_ready,
  output logic               px_valid,
  input  logic               px_ready,
  output logic [COORD_W-1:0] px_x,
  output logic [COORD_W-1:0] px_y,
  output logic [23:0]        px_color,
  output line_state_e        dbg_state
);

  // Pixel stream: a pixel moves when px_valid && px_ready; while stalled the
  // pixel register holds, and px_valid only drops after a transfer or on rst.

  localparam logic [COORD_W:0]   SCR_W = SCREEN_W[COORD_W:0];
  localparam logic [COORD_W:0]   SCR_H = SCREEN_H[COORD_W:0];
  localparam logic [COORD_W-1:0] ONE   = 1;

  line_state_e state, state_next;

  logic [COORD_W-1:0] pt_x0, pt_y0, pt_x1, pt_y1;
  logic [23:0]        color_r;
  logic               steep_r;
  logic [COORD_W-1:0] a_x0, a_y0, a_x1, a_y1;
  logic [COORD_W-1:0] cur_x, cur_y, end_x, dx_r, dy_r;
  logic signed [COORD_W+1:0] err_r;
  logic               ystep_neg_r, done_r;

  logic               su_steep, su_ystep_neg;
  logic [COORD_W-1:0] su_x0, su_y0, su_x1, su_y1;
  logic [COORD_W-1:0] su_px0, su_py0, su_px1, su_dx, su_dy;
  logic signed [COORD_W+1:0] su_err0;

  logic               unused_color_hi;
  assign unused_color_hi = ^line_color[31:24];

  line_setup #(.COORD_W(COORD_W)) u_setup (
    .x0(pt_x0), .y0(pt_y0), .x1(pt_x1), .y1(pt_y1),
    .steep(su_steep), .s_x0(su_x0), .s_y0(su_y0), .s_x1(su_x1), .s_y1(su_y1),
    .a_x0(a_x0), .a_y0(a_y0), .a_x1(a_x1), .a_y1(a_y1),
    .p_x0(su_px0), .p_y0(su_py0), .p_x1(su_px1),
    .dx(su_dx), .dy(su_dy), .err0(su_err0), .ystep_neg(su_ystep_neg)
  );

  logic                      out_free, step, last, visible;
  logic [COORD_W-1:0]        plot_x, plot_y, y_next;
  logic signed [COORD_W+1:0] err_dec, err_next;

  always_comb begin
    out_free = !px_valid || px_ready;
    step     = (state == ST_DRAW) && !done_r && out_free;
    last     = (cur_x == end_x);
    plot_x   = steep_r ? cur_y : cur_x;
    plot_y   = steep_r ? cur_x : cur_y;
    visible  = ({1'b0, plot_x} < SCR_W) && ({1'b0, plot_y} < SCR_H);
    err_dec  = err_r - signed'({2'b00, dy_r});
    err_next = err_dec;
    y_next   = cur_y;
    if (err_dec < 0) begin
      err_next = err_dec + signed'({2'b00, dx_r});
      y_next   = ystep_neg_r ? (cur_y - ONE) : (cur_y + ONE);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (line_trigger) state_next = ST_SETUP;
      ST_SETUP: state_next = ST_PREP;
      ST_PREP:  state_next = ST_DRAW;
      ST_DRAW: begin
        // A clipped final step leaves nothing to drain, so finish immediately.
        if (done_r && out_free)           state_next = ST_IDLE;
        else if (step && last && !visible) state_next = ST_IDLE;
      end
      default:  state_next = ST_IDLE;
    endcase
  end

  assign line_ready = (state == ST_IDLE);
  assign dbg_state  = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      pt_x0       <= '0;
      pt_y0       <= '0;
      pt_x1       <= '0;
      pt_y1       <= '0;
      color_r     <= '0;
      steep_r     <= 1'b0;
      a_x0        <= '0;
      a_y0        <= '0;
      a_x1        <= '0;
      a_y1        <= '0;
      cur_x       <= '0;
      cur_y       <= '0;
      end_x       <= '0;
      dx_r        <= '0;
      dy_r        <= '0;
      err_r       <= '0;
      ystep_neg_r <= 1'b0;
      done_r      <= 1'b0;
      px_valid    <= 1'b0;
      px_x        <= '0;
      px_y        <= '0;
      px_color    <= '0;
    end else begin
      state <= state_next;
      if (state == ST_IDLE) begin
        if (line_x0_valid)    pt_x0   <= line_point;
        if (line_y0_valid)    pt_y0   <= line_point;
        if (line_x1_valid)    pt_x1   <= line_point;
        if (line_y1_valid)    pt_y1   <= line_point;
        if (line_color_valid) color_r <= line_color[23:0];
      end
      if (state == ST_SETUP) begin
        steep_r <= su_steep;
        a_x0    <= su_x0;
        a_y0    <= su_y0;
        a_x1    <= su_x1;
        a_y1    <= su_y1;
      end
      if (state == ST_PREP) begin
        cur_x       <= su_px0;
        cur_y       <= su_py0;
        end_x       <= su_px1;
        dx_r        <= su_dx;
        dy_r        <= su_dy;
        err_r       <= su_err0;
        ystep_neg_r <= su_ystep_neg;
        done_r      <= 1'b0;
      end
      if (step) begin
        px_valid <= visible;
        px_x     <= plot_x;
        px_y     <= plot_y;
        px_color <= color_r;
        err_r    <= err_next;
        cur_y    <= y_next;
        cur_x    <= cur_x + ONE;
        done_r   <= last;
      end else if (px_valid && px_ready) begin
        px_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_line_engine.sv
// Bench for line_engine: directed scenarios plus randomized lines under random
// backpressure, scored against a behavioural Bresenham model through an expected queue.
module tb_line_engine;
  import line_engine_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] line_color = '0;
  logic [9:0]  line_point = '0;
  logic        line_color_valid = 1'b0;
  logic        line_x0_valid = 1'b0;
  logic        line_y0_valid = 1'b0;
  logic        line_x1_valid = 1'b0;
  logic        line_y1_valid = 1'b0;
  logic        line_trigger = 1'b0;
  logic        line_ready;
  logic        px_valid;
  logic        px_ready = 1'b1;
  logic [9:0]  px_x, px_y;
  logic [23:0] px_color;
  line_state_e dbg_state;

  line_engine dut (
    .clk(clk), .rst(rst), .line_color(line_color), .line_point(line_point),
    .line_color_valid(line_color_valid), .line_x0_valid(line_x0_valid),
    .line_y0_valid(line_y0_valid), .line_x1_valid(line_x1_valid),
    .line_y1_valid(line_y1_valid), .line_trigger(line_trigger),
    .line_ready(line_ready), .px_valid(px_valid), .px_ready(px_ready),
    .px_x(px_x), .px_y(px_y), .px_color(px_color), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset
  always #5 clk = ~clk;

  // ---------------- scoreboard state
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [43:0] exp_q[$];
  int          bp_mode  = 0;  // 0: always ready, 1: random, 2: driven by main

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic void push_px(input int x, input int y, input logic [31:0] c);
    logic [9:0] xx, yy;
    xx = x[9:0];
    yy = y[9:0];
    exp_q.push_back({xx, yy, c[23:0]});
  endfunction

  // Reference: plain integer Bresenham from the endpoint rules, with screen clipping.
  function automatic void push_line(input int x0, input int y0, input int x1, input int y1,
                                    input logic [31:0] c);
    int steep, t, dx, dy, err, ys, y, pxv, pyv;
    steep = ((y1 > y0 ? y1 - y0 : y0 - y1) > (x1 > x0 ? x1 - x0 : x0 - x1)) ? 1 : 0;
    if (steep != 0) begin
      t = x0; x0 = y0; y0 = t;
      t = x1; x1 = y1; y1 = t;
    end
    if (x0 > x1) begin
      t = x0; x0 = x1; x1 = t;
      t = y0; y0 = y1; y1 = t;
    end
    dx  = x1 - x0;
    dy  = (y1 > y0) ? y1 - y0 : y0 - y1;
    err = dx / 2;
    ys  = (y0 < y1) ? 1 : -1;
    y   = y0;
    for (int x = x0; x <= x1; x++) begin
      pxv = (steep != 0) ? y : x;
      pyv = (steep != 0) ? x : y;
      if (pxv < 800 && pyv < 600) push_px(pxv, pyv, c);
      err -= dy;
      if (err < 0) begin
        y   += ys;
        err += dx;
      end
    end
  endfunction

  // ---------------- background px_ready driver
  always @(posedge clk) begin
    #1;
    if (bp_mode == 0) px_ready = 1'b1;
    else if (bp_mode == 1) px_ready = ($urandom_range(0, 3) != 0);
  end

  // ---------------- monitor
  logic        stalled = 1'b0;
  logic [43:0] held;
  always @(negedge clk) begin
    if (rst) begin
      stalled = 1'b0;
    end else begin
      if (stalled && px_valid) check("hold_stable", {px_x, px_y, px_color}, held);
      if (px_valid && px_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL px_unexpected: got (%0d,%0d) expected no pixel (t=%0t)", px_x, px_y, $time);
        end else begin
          check("px", {px_x, px_y, px_color}, exp_q.pop_front());
        end
      end
      stalled = px_valid && !px_ready;
      held    = {px_x, px_y, px_color};
    end
  end

  // ---------------- driver tasks
  task automatic load_line(input int x0, input int y0, input int x1, input int y1,
                           input logic [31:0] col);
    @(posedge clk); #1;
    line_color = col; line_color_valid = 1'b1;
    line_point = x0[9:0]; line_x0_valid = 1'b1;
    @(posedge clk); #1;
    line_color_valid = 1'b0; line_x0_valid = 1'b0;
    line_point = y0[9:0]; line_y0_valid = 1'b1;
    @(posedge clk); #1;
    line_y0_valid = 1'b0;
    line_point = x1[9:0]; line_x1_valid = 1'b1;
    @(posedge clk); #1;
    line_x1_valid = 1'b0;
    line_point = y1[9:0]; line_y1_valid = 1'b1; line_trigger = 1'b1;
    @(posedge clk); #1;
    line_y1_valid = 1'b0; line_trigger = 1'b0;
  endtask

  task automatic wait_idle(input int bound, output int low);
    low = 0;
    forever begin
      @(negedge clk);
      if (line_ready) break;
      low++;
      if (low > bound) begin
        n_checks++;
        $display("FAIL idle_timeout: busy %0d cycles, limit %0d", low, bound);
        break;
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence
  initial begin
    int low;
    int x0, y0, x1, y1;
    logic [31:0] c;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_line_ready", line_ready, 1);
    check("rst_px_valid", px_valid, 0);
    check("rst_px_xy", {px_x, px_y}, 0);
    check("rst_px_color", px_color, 0);
    check("rst_state", dbg_state, ST_IDLE);

    // Horizontal line, timing of line_ready
    push_px(0, 0, 32'h00FF0000); push_px(1, 0, 32'h00FF0000);
    push_px(2, 0, 32'h00FF0000); push_px(3, 0, 32'h00FF0000);
    load_line(0, 0, 3, 0, 32'h00FF0000);
    wait_idle(100, low);
    check("horiz_ready_low", low, 7);
    check("horiz_drained", exp_q.size(), 0);

    // Steep, reversed endpoints
    push_px(0, 0, 32'h0000FF00); push_px(0, 1, 32'h0000FF00); push_px(1, 2, 32'h0000FF00);
    push_px(1, 3, 32'h0000FF00); push_px(2, 4, 32'h0000FF00); push_px(2, 5, 32'h0000FF00);
    load_line(2, 5, 0, 0, 32'hAB00FF00);
    wait_idle(100, low);
    check("steep_drained", exp_q.size(), 0);

    // Backpressure on the second pixel
    bp_mode = 2;
    @(posedge clk); #1 px_ready = 1'b1;
    push_px(0, 0, 32'h00123456); push_px(1, 1, 32'h00123456);
    push_px(2, 2, 32'h00123456); push_px(3, 3, 32'h00123456);
    load_line(0, 0, 3, 3, 32'h00123456);
    repeat (4) @(posedge clk);
    #1 px_ready = 1'b0;
    @(negedge clk);
    check("bp_stalled_px", {px_valid, px_x, px_y}, {1'b1, 10'd1, 10'd1});
    repeat (3) @(posedge clk);
    #1 px_ready = 1'b1;
    wait_idle(100, low);
    check("bp_drained", exp_q.size(), 0);
    bp_mode = 0;

    // Right-edge clipping
    push_px(798, 10, 32'h00112233); push_px(799, 10, 32'h00112233);
    load_line(798, 10, 801, 10, 32'h00112233);
    wait_idle(100, low);
    check("clip_ready_low", low, 6);
    check("clip_drained", exp_q.size(), 0);

    // Single point
    push_px(5, 7, 32'h00C0FFEE);
    load_line(5, 7, 5, 7, 32'h00C0FFEE);
    wait_idle(100, low);
    check("point_drained", exp_q.size(), 0);

    // Strobes and trigger while busy are ignored
    push_line(0, 0, 9, 0, 32'h00ABCDEF);
    load_line(0, 0, 9, 0, 32'h00ABCDEF);
    repeat (3) @(posedge clk);
    #1;
    line_point = 10'd50; line_x1_valid = 1'b1; line_trigger = 1'b1;
    line_color = 32'h00654321; line_color_valid = 1'b1;
    @(posedge clk); #1;
    line_x1_valid = 1'b0; line_trigger = 1'b0; line_color_valid = 1'b0;
    wait_idle(200, low);
    repeat (20) @(negedge clk);
    check("busy_no_extra", exp_q.size(), 0);
    check("busy_ready", line_ready, 1);

    // Randomized lines under random backpressure
    bp_mode = 1;
    for (int i = 0; i < 24; i++) begin
      if (i % 3 == 0) begin
        x0 = $urandom_range(0, 1023); y0 = $urandom_range(0, 1023);
        x1 = $urandom_range(0, 1023); y1 = $urandom_range(0, 1023);
      end else begin
        x0 = $urandom_range(780, 820); y0 = $urandom_range(0, 40);
        x1 = $urandom_range(780, 820); y1 = $urandom_range(570, 610);
        if (i % 2 == 0) begin
          x0 = $urandom_range(0, 30); x1 = $urandom_range(0, 30);
          y0 = $urandom_range(0, 30); y1 = $urandom_range(0, 30);
        end
      end
      c = $urandom;
      push_line(x0, y0, x1, y1, c);
      load_line(x0, y0, x1, y1, c);
      wait_idle(6000, low);
      check("rand_drained", exp_q.size(), 0);
    end
    bp_mode = 0;

    // Reset in the middle of a draw
    push_line(0, 0, 9, 0, 32'h00777777);
    load_line(0, 0, 9, 0, 32'h00777777);
    bp_mode = 2;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1; px_ready = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_px_valid", px_valid, 0);
    check("midrst_line_ready", line_ready, 1);
    exp_q.delete();
    rst = 1'b0; px_ready = 1'b1;
    bp_mode = 0;
    @(posedge clk); #1;
    push_px(0, 0, 32'h0);
    line_trigger = 1'b1;
    @(posedge clk); #1 line_trigger = 1'b0;
    wait_idle(100, low);
    repeat (5) @(negedge clk);
    check("post_rst_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
